restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter DW, default 8, meaning dividend width; the divisor, quotient and remainder width is DW/2, and only DW=8 is supported.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, meaning a request to begin a division, sampled only while the FSM is in IDLE.
REQ-005 SHALL have port dividend, input, 8 bits, meaning a two's-complement dividend.
REQ-006 SHALL have port divisor, input, 4 bits, meaning a two's-complement divisor.
REQ-007 SHALL have port quotient, output, 4 bits, meaning a registered two's-complement quotient.
REQ-008 SHALL have port remainder, output, 4 bits, meaning a registered two's-complement remainder.
REQ-009 SHALL have port busy, output, 1 bit, meaning a division is in progress.
REQ-010 SHALL have port done, output, 1 bit, meaning a one-cycle pulse that marks results valid.
REQ-011 SHALL have port ovf, output, 1 bit, meaning the true quotient lies outside [-8, 7].
REQ-012 SHALL have port dz, output, 1 bit, meaning the divisor was zero.

Function
REQ-013 SHALL implement the inverse of the team's 4x4 signed Booth multiplier, so that dividing its 8-bit product by y returns x with remainder 0.
REQ-014 SHALL use FSM states IDLE, CALC, FIX and DONE.
REQ-015 SHALL, when start=1 in IDLE at edge 0 with divisor!=0, latch |dividend| (8-bit unsigned, so -128 gives 128), |divisor|, and both signs; it SHALL then enter CALC with busy=1.
REQ-016 SHALL, in CALC, perform one restoring step per cycle for 8 cycles, driven by a 3-bit down-counter:
  - shift the partial remainder and quotient left;
  - trial-subtract |divisor|;
  - if the difference is non-negative, keep it and set quotient bit 1; otherwise restore.
REQ-017 SHALL compute internally a 5-bit partial remainder and an 8-bit magnitude quotient.
REQ-018 SHALL, in FIX (one cycle), apply signs:
  - quotient sign = dividend sign XOR divisor sign;
  - the remainder takes the dividend sign (truncating division);
  - ovf = signed quotient not in [-8, 7].
REQ-019 SHALL register quotient, remainder, ovf and dz at edge 10, and SHALL assert done for exactly the cycle after edge 10, with busy falling at the same edge.
REQ-020 SHALL therefore have a fixed latency of 10 cycles from the start edge to done.
REQ-021 SHALL, when start=1 in IDLE with divisor=0, skip CALC and FIX: at edge 1 it SHALL set dz=1, ovf=0, quotient=0 and remainder=0, and pulse done (latency 1).
REQ-022 SHALL ignore start while busy=1, and SHALL NOT change the latched operands then.
REQ-023 SHALL accept a start asserted in the same cycle as done, since the FSM has returned to IDLE.
REQ-024 SHALL hold quotient, remainder, ovf and dz stable from done until the next result registration.
REQ-025 SHALL NOT register dividend or divisor inputs after the start edge; changes after that edge SHALL NOT affect the result.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, force state=IDLE, busy=0, done=0, quotient=0, remainder=0, ovf=0, dz=0 and counter=0.
REQ-027 SHALL abort any division in progress when rst is asserted mid-operation, with no done pulse.
REQ-028 SHALL give rst priority over start in the same cycle.

Configuration
REQ-029 SHALL, when DIV_OVERFLOW_SAT_EN is defined, saturate an overflowing quotient to 4'b0111 (positive) or 4'b1000 (negative).
REQ-030 SHALL, when DIV_OVERFLOW_SAT_EN is undefined, output the low 4 bits of the true two's-complement quotient on overflow.
REQ-031 SHALL report ovf identically in both builds and SHALL leave the remainder unaffected by DIV_OVERFLOW_SAT_EN.

Verification
REQ-032 SHALL cover: dividend=8'b11110100 (-12), divisor=4'b0010 (2) -> quotient=4'b1010 (-6), remainder=0, ovf=0, done exactly 10 cycles after start.
REQ-033 SHALL cover: dividend=7, divisor=-2 -> quotient=4'b1101, remainder=4'b0001; and dividend=-7, divisor=2 -> quotient=4'b1101, remainder=4'b1111.
REQ-034 SHALL cover: dividend=100, divisor=3 -> ovf=1, remainder=4'b0001; quotient=4'b0111 with DIV_OVERFLOW_SAT_EN, 4'b0001 without.
REQ-035 SHALL cover: dividend=-128, divisor=-8 -> ovf=1, remainder=0; quotient=4'b0111 with DIV_OVERFLOW_SAT_EN, 4'b0000 without.
REQ-036 SHALL cover: divisor=0 -> dz=1, quotient=0, remainder=0, done one cycle after start.
REQ-037 SHALL cover: start pulsed again at cycle 4 with new operands -> ignored and the first result unchanged; then rst at cycle 5 of a new division -> no done pulse, all outputs 0, next start completes normally.

Source files
------------

// File: rtl/restoring_divider.sv
// Signed 8-by-4 restoring divider: one quotient bit per cycle, then a sign fix-up.
// Optional build macro DIV_OVERFLOW_SAT_EN saturates an out-of-range quotient.
module restoring_divider #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   dividend,
  input  logic [DW/2-1:0] divisor,
  output logic [DW/2-1:0] quotient,
  output logic [DW/2-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic            dz,
  output logic [1:0]      dbg_state
);

  localparam int HW = DW / 2;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] ONE_W    = 1;
  localparam logic [HW-1:0] ONE_H    = 1;
  localparam logic [CW-1:0] ONE_C    = 1;
  localparam logic [DW-1:0] QMAX_POS = (1 << (HW - 1)) - 1;
  localparam logic [DW-1:0] QMAX_NEG = (1 << (HW - 1));

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW:0]     rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [HW-1:0]   dmag_q, dmag_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_dvd_q, neg_dvd_d;
  logic            dz_pend_q, dz_pend_d;
  logic [HW-1:0]   q_fix_q, q_fix_d;
  logic [HW-1:0]   r_fix_q, r_fix_d;
  logic            ovf_fix_q, ovf_fix_d;
  logic [HW-1:0]   quotient_q, quotient_d;
  logic [HW-1:0]   remainder_q, remainder_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [HW:0]     rem_sh;
  logic [HW+1:0]   diff;
  logic [DW-1:0]   q_neg;
  logic [HW-1:0]   q_low;
  logic            ovf_calc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    neg_q_d     = neg_q_q;
    neg_dvd_d   = neg_dvd_q;
    dz_pend_d   = dz_pend_q;
    q_fix_d     = q_fix_q;
    r_fix_d     = r_fix_q;
    ovf_fix_d   = ovf_fix_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    rem_sh   = {rem_q[HW-1:0], quo_q[DW-1]};
    diff     = {1'b0, rem_sh} - {2'b00, dmag_q};
    q_neg    = ~quo_q + ONE_W;
    q_low    = neg_q_q ? q_neg[HW-1:0] : quo_q[HW-1:0];
    ovf_calc = neg_q_q ? (quo_q > QMAX_NEG) : (quo_q > QMAX_POS);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_dvd_d = dividend[DW-1];
          neg_q_d   = dividend[DW-1] ^ divisor[HW-1];
          quo_d     = dividend[DW-1] ? (~dividend + ONE_W) : dividend;
          dmag_d    = divisor[HW-1] ? (~divisor + ONE_H) : divisor;
          rem_d     = '0;
          cnt_d     = '1;
          busy_d    = 1'b1;
          if (divisor == '0) begin
            // Divide-by-zero bypasses the datapath and reports on the next edge.
            dz_pend_d = 1'b1;
            q_fix_d   = '0;
            r_fix_d   = '0;
            ovf_fix_d = 1'b0;
            state_d   = DONE;
          end else begin
            dz_pend_d = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        quo_d = {quo_q[DW-2:0], ~diff[HW+1]};
        rem_d = diff[HW+1] ? rem_sh : diff[HW:0];
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        ovf_fix_d = ovf_calc;
`ifdef DIV_OVERFLOW_SAT_EN
        q_fix_d   = ovf_calc ? (neg_q_q ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}})
                             : q_low;
`else
        q_fix_d   = q_low;
`endif
        // Truncating division: remainder carries the dividend's sign.
        r_fix_d   = neg_dvd_q ? (~rem_q[HW-1:0] + ONE_H) : rem_q[HW-1:0];
        state_d   = DONE;
      end
      DONE: begin
        quotient_d  = q_fix_q;
        remainder_d = r_fix_q;
        ovf_d       = ovf_fix_q;
        dz_d        = dz_pend_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_dvd_q   <= 1'b0;
      dz_pend_q   <= 1'b0;
      q_fix_q     <= '0;
      r_fix_q     <= '0;
      ovf_fix_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      neg_q_q     <= neg_q_d;
      neg_dvd_q   <= neg_dvd_d;
      dz_pend_q   <= dz_pend_d;
      q_fix_q     <= q_fix_d;
      r_fix_q     <= r_fix_d;
      ovf_fix_q   <= ovf_fix_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: expected results are queued at issue time
// and a monitor compares them against every done pulse, including completion cycle.
module tb_restoring_divider;

`ifdef DIV_OVERFLOW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       dz;
  logic [1:0] dbg_state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Result word: {quotient, remainder, ovf, dz}
  logic [9:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [9:0] hold_val;
  logic       hold_valid;

  restoring_divider #(.DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .ovf(ovf), .dz(dz), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    logic [9:0] got;
    logic [9:0] e;
    int         ec;
    forever begin
      @(negedge clk);
      got = {quotient, remainder, ovf, dz};
      if (!rst && done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d got=%h", cyc, got);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL result cyc=%0d got q=%b r=%b ovf=%b dz=%b exp q=%b r=%b ovf=%b dz=%b",
                     cyc, got[9:6], got[5:2], got[1], got[0], e[9:6], e[5:2], e[1], e[0]);
          end
          checks++;
          if (cyc != ec) begin
            failures++;
            $display("FAIL latency done_at=%0d exp=%0d", cyc, ec);
          end
          hold_val   = e;
          hold_valid = 1'b1;
        end
      end else if (!rst && hold_valid) begin
        checks++;
        if (got !== hold_val) begin
          failures++;
          $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, got, hold_val);
        end
      end
    end
  endtask

  task automatic run_div(input logic [7:0] dvd, input logic [3:0] dvs,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic eo, input logic edz, input int lat, input int ignore_at);
    bit got_done;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({eq, er, eo, edz});
    exp_cyc_q.push_back(cyc + lat);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%b exp=1", busy);
    end
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (ignore_at != 0 && i + 1 == ignore_at) begin
        start    = 1'b1;
        dividend = 8'h55;
        divisor  = 4'h3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL timeout dvd=%h dvs=%h got=no_done exp=done", dvd, dvs);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({quotient, remainder, ovf, dz, busy, done, dbg_state} !== 16'h0) begin
      failures++;
      $display("FAIL %s got q=%b r=%b ovf=%b dz=%b busy=%b done=%b st=%0d exp all 0",
               name, quotient, remainder, ovf, dz, busy, done, dbg_state);
    end
  endtask

  initial begin
    hold_valid = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back issues: each new start lands in the previous done cycle.
    run_div(8'hF4, 4'h2, 4'b1010, 4'b0000, 1'b0, 1'b0, 10, 0);   // -12 / 2
    run_div(8'h07, 4'hE, 4'b1101, 4'b0001, 1'b0, 1'b0, 10, 0);   // 7 / -2
    run_div(8'hF9, 4'h2, 4'b1101, 4'b1111, 1'b0, 1'b0, 10, 0);   // -7 / 2
    run_div(8'h64, 4'h3, SAT ? 4'b0111 : 4'b0001, 4'b0001, 1'b1, 1'b0, 10, 0); // 100 / 3
    run_div(8'h80, 4'h8, SAT ? 4'b0111 : 4'b0000, 4'b0000, 1'b1, 1'b0, 10, 0); // -128 / -8
    run_div(8'h2A, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 0);    // divide by zero
    run_div(8'hF1, 4'hD, 4'b0101, 4'b0000, 1'b0, 1'b0, 10, 0);   // -15 / -3
    run_div(8'h40, 4'h8, 4'b1000, 4'b0000, 1'b0, 1'b0, 10, 0);   // 64 / -8
    run_div(8'hC8, 4'h7, 4'b1000, 4'b0000, 1'b0, 1'b0, 10, 0);   // -56 / 7
    run_div(8'h31, 4'h7, 4'b0111, 4'b0000, 1'b0, 1'b0, 10, 0);   // 49 / 7
    run_div(8'hF3, 4'hC, 4'b0011, 4'b1111, 1'b0, 1'b0, 10, 0);   // -13 / -4
    run_div(8'h00, 4'h5, 4'b0000, 4'b0000, 1'b0, 1'b0, 10, 0);   // 0 / 5
    run_div(8'h09, 4'hF, SAT ? 4'b1000 : 4'b0111, 4'b0000, 1'b1, 1'b0, 10, 0); // 9 / -1
    run_div(8'hF8, 4'h1, 4'b1000, 4'b0000, 1'b0, 1'b0, 10, 0);   // -8 / 1
    run_div(8'h08, 4'h1, SAT ? 4'b0111 : 4'b1000, 4'b0000, 1'b1, 1'b0, 10, 0); // 8 / 1
    run_div(8'h0D, 4'h4, 4'b0011, 4'b0001, 1'b0, 1'b0, 10, 4);   // 13 / 4, stray start at cycle 4

    // Abort mid-division: no done may follow, outputs clear.
    repeat (2) @(negedge clk);
    dividend = 8'h32;
    divisor  = 4'h7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    hold_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("abort_reset");
    rst = 1'b0;
    hold_val   = '0;
    hold_valid = 1'b1;
    repeat (14) @(negedge clk);

    run_div(8'hEC, 4'h3, 4'b1010, 4'b1110, 1'b0, 1'b0, 10, 0);   // -20 / 3
    repeat (4) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
